// File: rtl/single_port_sync_ram_core.sv
// Single-port synchronous RAM with a shared tri-state data bus and a registered read port.
// Optional SPRAM_CLEAR_ON_RESET_EN: zero every word after reset release, with busy held high meanwhile.
module single_port_sync_ram_core #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  cs,
  input  logic                  we,
  input  logic                  oe,
  output logic                  busy
);

  localparam int                  IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_q, rd_d;
  logic                  in_range;
  logic [IDX_W-1:0]      user_idx;
  logic                  wr_en;
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;

  // Addresses at or beyond DEPTH never touch the array.
  assign in_range = ({1'b0, addr} < DEPTH_W);
  assign user_idx = addr[IDX_W-1:0];

`ifdef SPRAM_CLEAR_ON_RESET_EN
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  logic             clr_active_q, clr_active_d;
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;

  // Down-counter walks DEPTH-1..0, one word per cycle; terminal count is 0.
  always_comb begin
    clr_active_d = clr_active_q;
    clr_cnt_d    = clr_cnt_q;
    if (clr_active_q) begin
      if (clr_cnt_q == '0) clr_active_d = 1'b0;
      else                 clr_cnt_d    = clr_cnt_q - IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_active_q <= 1'b1;
      clr_cnt_q    <= LAST_IDX;
    end else begin
      clr_active_q <= clr_active_d;
      clr_cnt_q    <= clr_cnt_d;
    end
  end

  // Held low during reset itself; the clear starts at release.
  assign busy = clr_active_q & rst_n;
`else
  assign busy = 1'b0;
`endif

  always_comb begin
    wr_en   = cs & we & in_range;
    wr_idx  = user_idx;
    wr_data = data;
`ifdef SPRAM_CLEAR_ON_RESET_EN
    if (busy) begin
      wr_en   = 1'b1;
      wr_idx  = clr_cnt_q;
      wr_data = '0;
    end
`endif
  end

  always_comb begin
    rd_d = rd_q;
    if (cs & ~we & ~busy) rd_d = in_range ? mem[user_idx] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_q <= '0;
    else        rd_q <= rd_d;
  end

  // Array is never reset so it can map onto a RAM macro.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign data = (cs & oe & ~we & ~busy) ? rd_q : 'z;

endmodule

// File: tb/tb_single_port_sync_ram_core.sv
// Directed bench for single_port_sync_ram_core with a reference memory and expected-read queue.
// Works with or without SPRAM_CLEAR_ON_RESET_EN defined.
module tb_single_port_sync_ram_core;

  localparam int AW = 6;
  localparam int DW = 8;
  localparam int DP = 40;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [AW-1:0] addr;
  logic          cs, we, oe;
  logic          busy;
  wire  [DW-1:0] data;
  logic          tb_en;
  logic [DW-1:0] tb_drv;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model [DP];
  logic [DW-1:0] sb_q [$];

  assign data = tb_en ? tb_drv : 'z;

  always #5 clk = ~clk;

  single_port_sync_ram_core #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH     (DP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .addr (addr),
    .data (data),
    .cs   (cs),
    .we   (we),
    .oe   (oe),
    .busy (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clocked operation; reads push their expected word and are compared one edge later.
  task automatic step(input logic c, input logic w, input logic o,
                      input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
    logic [DW-1:0] exp;
    cs = c; we = w; oe = o; addr = a; tb_drv = d; tb_en = w;
    if (c && w && int'(a) < DP) model[a] = d;
    if (c && !w) sb_q.push_back((int'(a) < DP) ? model[a] : '0);
    @(posedge clk); #1;
    if (c && !w) begin
      exp = sb_q.pop_front();
      if (o) check(tag, data, exp);
    end
    tb_en = 1'b0;
  endtask

  task automatic wait_clear(input string tag);
    int n;
    #1;
`ifdef SPRAM_CLEAR_ON_RESET_EN
    check({tag, "_busy_on_release"}, busy, 1);
    n = 0;
    cs = 1'b1; we = 1'b1; oe = 1'b1; tb_en = 1'b1; tb_drv = 8'hEE;
    while (n < DP + 8) begin
      case (n % 3)
        0:       addr = '0;
        1:       addr = AW'(15);
        default: addr = AW'(DP - 1);
      endcase
      @(posedge clk); #1;
      n++;
      if (!busy) break;
    end
    tb_en = 1'b0; cs = 1'b0; we = 1'b0;
    check({tag, "_busy_cycles"}, n, DP);
    for (int i = 0; i < DP; i++) model[i] = '0;
`else
    n = 0;
    check({tag, "_busy_tied_low"}, {31'd0, busy}, n);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tb_en = 1'b0; tb_drv = '0; cs = 1'b1; we = 1'b0; oe = 1'b1; addr = '0;
    #1 rst_n = 1'b0;
    #3;
    check("reset_data", data, 0);
    check("reset_busy", busy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clear("init");

    for (int i = 0; i < 16; i++) step(1, 1, 1, AW'(i), DW'($urandom_range(0, 255)), "wr");
    for (int i = 0; i < 16; i++) step(1, 0, 1, AW'(i), '0, "rd_0_15");

    step(1, 1, 0, AW'(7), 8'h11, "b2b_wr");
    step(1, 0, 1, AW'(7), '0, "b2b_rd");

    step(1, 1, 0, AW'(3), 8'hAA, "desel_wr");
    step(0, 1, 1, AW'(3), 8'h55, "desel_blocked_wr");
    step(1, 0, 1, AW'(3), '0, "desel_rd");

    // rd_q now holds 0xAA; any RAM drive would disturb the bench's 5.
    cs = 1'b1; we = 1'b0; oe = 1'b0; addr = AW'(3); tb_en = 1'b1; tb_drv = 8'h05;
    #1 check("tri_oe0", data, 8'h05);
    @(posedge clk); #1;
    check("tri_oe0_after_edge", data, 8'h05);
    tb_en = 1'b0; oe = 1'b1;
    #1 check("oe_turn_on", data, 8'hAA);
    oe = 1'b0; tb_en = 1'b1; tb_drv = 8'h05;
    #1 check("oe_turn_off", data, 8'h05);
    we = 1'b1; oe = 1'b1; addr = AW'(20);
    model[20] = 8'h05;
    #1 check("tri_we1", data, 8'h05);
    @(posedge clk); #1;
    cs = 1'b0; we = 1'b0; oe = 1'b1;
    #1 check("tri_cs0", data, 8'h05);
    @(posedge clk); #1;
    tb_en = 1'b0;
    step(1, 0, 1, AW'(20), '0, "tri_we1_readback");

    step(1, 1, 0, AW'(DP - 1), 8'hC3, "last_wr");
    step(1, 0, 1, AW'(DP - 1), '0, "last_rd");
    step(1, 1, 0, AW'(DP), 8'h77, "oor40_wr");
    step(1, 0, 1, AW'(DP), '0, "oor40_rd");
    step(1, 1, 0, AW'(50), 8'h99, "oor50_wr");
    step(1, 0, 1, AW'(50), '0, "oor50_rd");

    step(1, 1, 0, AW'(2), 8'h3C, "pre_reset_wr");
    step(1, 0, 1, AW'(2), '0, "pre_reset_rd");
    #2 rst_n = 1'b0;
    #1 check("reset_async_data", data, 0);
    #1 rst_n = 1'b1;
    wait_clear("mid");
    step(1, 0, 1, AW'(2), '0, "post_reset_rd");
    step(1, 0, 1, AW'(0), '0, "post_reset_rd0");
    step(1, 0, 1, AW'(15), '0, "post_reset_rd15");
    step(1, 0, 1, AW'(DP - 1), '0, "post_reset_rd_last");

    cs = 1'b0; we = 1'b0; oe = 1'b0;
    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
